// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: rename/dispatch sequencing controller.
// Picks whether the instruction-queue head dispatches this cycle, steers it to
// the ALU/MUL/DIV reservation station, gates free-list pops, tags it with the
// dynamic order counter, and blocks dispatch while the RAT recovers from a flush.
// Optional build macro: DISPATCH_PERF_EN (saturating stall-cycle counters).
module dispatch_ctrl #(
  parameter int unsigned ORDER_W        = 64,
  parameter int unsigned RECOVER_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iq_empty,
  input  logic [31:0]        iq_inst,
  input  logic               free_list_empty,
  input  logic               rob_full,
  input  logic [2:0]         rs_full,
  input  logic               flush,
  input  logic [ORDER_W-1:0] flush_order,
  output logic               iq_dequeue,
  output logic               fl_dequeue,
  output logic               rob_alloc,
  output logic [2:0]         rs_sel,
  output logic [ORDER_W-1:0] dispatch_order,
  output logic               busy_recover,
  output logic [2:0]         stall_cause,
  output logic [31:0]        perf_stall_rob,
  output logic [31:0]        perf_stall_rs,
  output logic [31:0]        perf_stall_fl
);

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned PERF_W    = 32;
  localparam logic [6:0]  OP_REG    = 7'b0110011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  F7_MULDIV = 7'b0000001;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RECOVER_CYCLES - 1);

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   recover_cnt;
  logic [ORDER_W-1:0] order;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [6:0] funct7;
  logic       funct3_hi;
  logic [2:0] cls;
  logic       is_muldiv;
  logic       needs_pd;
  logic       rs_blocked;
  logic       fl_blocked;
  logic       eligible;
  logic       fire;
  logic       unused_inst;

  assign opcode      = iq_inst[6:0];
  assign rd          = iq_inst[11:7];
  assign funct3_hi   = iq_inst[14];
  assign funct7      = iq_inst[31:25];
  assign unused_inst = ^iq_inst[24:12];

  // Decode class (one-hot, RS bit order) and whether a physical register is consumed
  always_comb begin
    is_muldiv  = (opcode == OP_REG) && (funct7 == F7_MULDIV);
    cls        = is_muldiv ? (funct3_hi ? 3'b100 : 3'b010) : 3'b001;
    needs_pd   = !((opcode == OP_STORE) || (opcode == OP_BRANCH)) && (rd != 5'd0);
    rs_blocked = |(rs_full & cls);
    fl_blocked = needs_pd && free_list_empty;
    eligible   = rst && (state == RUN) && !flush && !iq_empty;
    fire       = eligible && !rob_full && !rs_blocked && !fl_blocked;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: flush always (re)enters RECOVER; leave when the counter hits zero
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (flush) state_next = RECOVER;
      RECOVER: begin
        if (flush) begin
          state_next = RECOVER;
        end else if (recover_cnt == '0) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Recovery countdown and dynamic order counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      recover_cnt <= '0;
      order       <= '0;
    end else if (flush) begin
      recover_cnt <= CNT_LOAD;
      order       <= flush_order;
    end else begin
      if ((state == RECOVER) && (recover_cnt != '0)) begin
        recover_cnt <= recover_cnt - CNT_W'(1);
      end
      if (fire) begin
        order <= order + ORDER_W'(1);
      end
    end
  end

  // Dispatch strobes and stall reporting; everything reads low while reset is asserted
  always_comb begin
    iq_dequeue     = 1'b0;
    fl_dequeue     = 1'b0;
    rob_alloc      = 1'b0;
    rs_sel         = 3'b000;
    stall_cause    = 3'b000;
    dispatch_order = rst ? order : '0;
    busy_recover   = rst && (state == RECOVER);
    if (fire) begin
      iq_dequeue = 1'b1;
      rob_alloc  = 1'b1;
      rs_sel     = cls;
      fl_dequeue = needs_pd;
    end else if (eligible) begin
      stall_cause = {fl_blocked, rs_blocked, rob_full};
    end
  end

`ifdef DISPATCH_PERF_EN
  logic [PERF_W-1:0] cnt_rob;
  logic [PERF_W-1:0] cnt_rs;
  logic [PERF_W-1:0] cnt_fl;

  // Saturating stall-cycle counters; only reset clears them
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_rob <= '0;
      cnt_rs  <= '0;
      cnt_fl  <= '0;
    end else begin
      if (stall_cause[0] && (cnt_rob != '1)) cnt_rob <= cnt_rob + PERF_W'(1);
      if (stall_cause[1] && (cnt_rs  != '1)) cnt_rs  <= cnt_rs  + PERF_W'(1);
      if (stall_cause[2] && (cnt_fl  != '1)) cnt_fl  <= cnt_fl  + PERF_W'(1);
    end
  end

  assign perf_stall_rob = rst ? cnt_rob : '0;
  assign perf_stall_rs  = rst ? cnt_rs  : '0;
  assign perf_stall_fl  = rst ? cnt_fl  : '0;
`else
  assign perf_stall_rob = '0;
  assign perf_stall_rs  = '0;
  assign perf_stall_fl  = '0;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Scoreboard bench for dispatch_ctrl: directed stimulus pushes expected dispatches,
// a negedge monitor pops and compares whenever the DUT dequeues.
module tb_dispatch_ctrl;

  localparam int unsigned ORDER_W = 64;
  localparam logic [31:0] ADD_X0 = 32'h0020_8033;
  localparam logic [31:0] MUL_X3 = 32'h0220_81B3;
  localparam logic [31:0] DIV_X3 = 32'h0220_C1B3;
  localparam logic [31:0] SW_I   = 32'h0031_2023;

  typedef struct packed {
    logic [2:0]         rs_sel;
    logic               fl;
    logic [ORDER_W-1:0] order;
  } want_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               iq_empty;
  logic [31:0]        iq_inst;
  logic               free_list_empty;
  logic               rob_full;
  logic [2:0]         rs_full;
  logic               flush;
  logic [ORDER_W-1:0] flush_order;
  logic               iq_dequeue;
  logic               fl_dequeue;
  logic               rob_alloc;
  logic [2:0]         rs_sel;
  logic [ORDER_W-1:0] dispatch_order;
  logic               busy_recover;
  logic [2:0]         stall_cause;
  logic [31:0]        perf_stall_rob;
  logic [31:0]        perf_stall_rs;
  logic [31:0]        perf_stall_fl;

  want_t want_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  dispatch_ctrl #(.ORDER_W(ORDER_W), .RECOVER_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .iq_empty(iq_empty), .iq_inst(iq_inst),
    .free_list_empty(free_list_empty), .rob_full(rob_full), .rs_full(rs_full),
    .flush(flush), .flush_order(flush_order), .iq_dequeue(iq_dequeue),
    .fl_dequeue(fl_dequeue), .rob_alloc(rob_alloc), .rs_sel(rs_sel),
    .dispatch_order(dispatch_order), .busy_recover(busy_recover),
    .stall_cause(stall_cause), .perf_stall_rob(perf_stall_rob),
    .perf_stall_rs(perf_stall_rs), .perf_stall_fl(perf_stall_fl)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic expect_fire(input logic [2:0] rs, input logic fl, input logic [ORDER_W-1:0] ord);
    want_t w;
    w.rs_sel = rs;
    w.fl     = fl;
    w.order  = ord;
    want_q.push_back(w);
  endtask

  // Monitor: every dequeue must match the oldest expected dispatch
  always @(negedge clk) begin
    want_t w;
    if (iq_dequeue) begin
      if (want_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_fire: got dispatch order %0h, required no dispatch (t=%0t)",
                 dispatch_order, $time);
      end else begin
        w = want_q.pop_front();
        check("fire_rs_sel", 64'(rs_sel), 64'(w.rs_sel));
        check("fire_fl_dequeue", 64'(fl_dequeue), 64'(w.fl));
        check("fire_rob_alloc", 64'(rob_alloc), 64'd1);
        check("fire_order", dispatch_order, w.order);
      end
    end else begin
      check("idle_strobes", 64'({rob_alloc, fl_dequeue, rs_sel}), 64'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; iq_empty = 1'b0; iq_inst = ADD_X0; free_list_empty = 1'b0;
    rob_full = 1'b0; rs_full = 3'b000; flush = 1'b0; flush_order = '0;
    next(); mid();
    check("rst_iq_dequeue", 64'(iq_dequeue), 64'd0);
    check("rst_order", dispatch_order, 64'd0);
    check("rst_busy", 64'(busy_recover), 64'd0);
    check("rst_stall", 64'(stall_cause), 64'd0);

    // add x0: ALU, no physical register
    next(); rst = 1'b1; expect_fire(3'b001, 1'b0, 64'd0); mid();
    next(); iq_empty = 1'b1; mid();
    check("order_after_first", dispatch_order, 64'd1);
    check("empty_no_stall", 64'(stall_cause), 64'd0);

    // mul blocked by its own RS only
    next(); iq_empty = 1'b0; iq_inst = MUL_X3; rs_full = 3'b010; mid();
    check("mul_rs_stall", 64'(stall_cause), 64'b010);
    next(); rs_full = 3'b001; expect_fire(3'b010, 1'b1, 64'd1); mid();

    // div blocked by free list; store ignores empty free list
    next(); rs_full = 3'b000; iq_inst = DIV_X3; free_list_empty = 1'b1; mid();
    check("div_fl_stall", 64'(stall_cause), 64'b100);
    next(); iq_inst = SW_I; expect_fire(3'b001, 1'b0, 64'd2); mid();

    // all three stall causes at once, then div with only MUL RS full
    next(); iq_inst = DIV_X3; rob_full = 1'b1; rs_full = 3'b100; mid();
    check("multi_stall", 64'(stall_cause), 64'b111);
    next(); rob_full = 1'b0; rs_full = 3'b010; free_list_empty = 1'b0;
    expect_fire(3'b100, 1'b1, 64'd3); mid();
    check("fire_no_stall", 64'(stall_cause), 64'd0);

    // flush beats fire, recovery lasts 2 cycles
    next(); rs_full = 3'b000; iq_inst = ADD_X0; flush = 1'b1; flush_order = 64'h40; mid();
    check("flush_stall", 64'(stall_cause), 64'd0);
    check("flush_cycle_busy", 64'(busy_recover), 64'd0);
    next(); flush = 1'b0; mid(); check("recover_busy_1", 64'(busy_recover), 64'd1);
    next(); mid(); check("recover_busy_2", 64'(busy_recover), 64'd1);
    next(); expect_fire(3'b001, 1'b0, 64'h40); mid();
    check("recover_done", 64'(busy_recover), 64'd0);

    // re-arm on last RECOVER cycle
    next(); flush = 1'b1; flush_order = 64'h10; mid();
    next(); flush = 1'b0; mid(); check("rearm_busy_a", 64'(busy_recover), 64'd1);
    next(); flush = 1'b1; flush_order = 64'h80; mid();
    check("rearm_busy_b", 64'(busy_recover), 64'd1);
    next(); flush = 1'b0; mid(); check("rearm_busy_c", 64'(busy_recover), 64'd1);
    next(); mid(); check("rearm_busy_d", 64'(busy_recover), 64'd1);
    next(); expect_fire(3'b001, 1'b0, 64'h80); mid();
    check("rearm_done", 64'(busy_recover), 64'd0);

    // reset in the middle of RECOVER
    next(); flush = 1'b1; flush_order = 64'h55; mid();
    next(); flush = 1'b0; rst = 1'b0; mid();
    check("midrst_busy", 64'(busy_recover), 64'd0);
    check("midrst_order", dispatch_order, 64'd0);
    next(); rst = 1'b1; expect_fire(3'b001, 1'b0, 64'd0); mid();
    check("postrst_busy", 64'(busy_recover), 64'd0);

    // order wrap
    next(); flush = 1'b1; flush_order = '1; mid();
    next(); flush = 1'b0; mid();
    next(); mid();
    next(); expect_fire(3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF); mid();
    next(); expect_fire(3'b001, 1'b0, 64'd0); mid();

    // five cycles of ROB-full stall
    next(); rob_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mid();
      check("rob_stall", 64'(stall_cause), 64'b001);
      if (i < 4) next();
    end
    next(); rob_full = 1'b0; iq_empty = 1'b1; mid();
`ifdef DISPATCH_PERF_EN
    check("perf_rob", 64'(perf_stall_rob), 64'd5);
    check("perf_rs", 64'(perf_stall_rs), 64'd0);
    check("perf_fl", 64'(perf_stall_fl), 64'd0);
`else
    check("perf_rob_off", 64'(perf_stall_rob), 64'd0);
    check("perf_rs_off", 64'(perf_stall_rs), 64'd0);
    check("perf_fl_off", 64'(perf_stall_fl), 64'd0);
`endif

    next(); mid();
    check("pending_dispatches", 64'(want_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
